matrix_result_streamer: RTL and testbench
=========================================

// Module: matrix_result_streamer
// PURPOSE
//  Sink side of the matrix calculator result interface. Captures one packed result
//  (up to 25 x 16-bit elements + 6-bit dim) on a done pulse and serialises it as a
//  byte frame over a valid/ready stream toward the host link. Reports calculator
//  errors as a one-byte error frame.
// PARAMETERS
//  ELEM_W     16   element width in bits; fixed at 16, other values unsupported
//  MAX_ELEMS  25   element slots in res_data
//  DIM_W      6    dim width {rows[5:3], cols[2:0]}
// PORTS
//  clk        in   1    clock
//  rst_n      in   1    reset, asynchronous, active-low
//  res_done   in   1    1-cycle pulse: res_data/res_dim valid this cycle
//  res_error  in   1    1-cycle pulse: calculator rejected the operation
//  res_dim    in   6    {rows, cols} of the result
//  res_data   in   400  element i at [i*16 +: 16], row-major
//  tx_data    out  8    stream byte
//  tx_valid   out  1    tx_data valid
//  tx_ready   in   1    downstream accepts; transfer = tx_valid & tx_ready
//  tx_last    out  1    marks final byte of frame (qualified by tx_valid)
//  busy       out  1    frame in progress (state != IDLE)
//  overrun    out  1    1-cycle pulse: res_done/res_error dropped while busy
// BEHAVIOUR
//  - Reset: tx_data=0, tx_valid=0, tx_last=0, busy=0, overrun=0, state IDLE,
//    capture regs 0. Reset mid-frame abandons the frame; tx_valid drops asynchronously.
//  - All outputs registered. States: IDLE, HDR, E_HI, E_LO, CSUM, ERR.
//  - IDLE: edge with res_error=1 -> ERR (error wins over simultaneous res_done).
//    Edge with res_done=1: n = rows*cols. If n > MAX_ELEMS -> ERR; else latch
//    res_data, res_dim, n; -> HDR. tx_valid high in the cycle after that edge.
//  - HDR byte = {2'b00, res_dim}. After transfer: n==0 -> frame ends (tx_last on
//    header); else idx=0 -> E_HI.
//  - E_HI sends elem[idx][15:8]; E_LO sends elem[idx][7:0], then idx++; after
//    idx==n-1 low byte the frame ends (or -> CSUM when enabled).
//  - ERR: single byte 0xEE with tx_last=1; never carries checksum. 0xEE cannot
//    collide with a header (header bits [7:6] are 00).
//  - Handshake: one byte per cycle when tx_ready stays 1 (no bubbles). While
//    tx_valid & !tx_ready, tx_data/tx_last held stable. tx_valid never drops
//    without a transfer (except reset).
//  - End of frame: on final transfer edge, tx_valid/tx_last/busy -> 0, state IDLE;
//    a new res_done is accepted on the next edge.
//  - Frame length = 1 + 2n (+1 with checksum). rows or cols of 0 gives n=0.
//  - res_done/res_error sampled while busy: ignored, overrun=1 for that one cycle.
//  - n computed as 6-bit product of 3-bit fields (max 49); no truncation.
// CONFIGURATION
//  MATRIX_STREAM_CHECKSUM_EN defined: after last element byte, state CSUM sends
//  XOR of all prior bytes of the frame (header included) with tx_last=1; tx_last
//  not asserted on the last element byte. Undefined: CSUM state and XOR register
//  absent, tx_last on last element byte (or header when n=0).
// TESTING
//  1. dim=6'o22, elems 0x0102,0x0304,0x0506,0x0708, tx_ready=1 -> bytes 12,01,02,
//     03,04,05,06,07,08 on 9 consecutive cycles, tx_last on 0x08, busy then 0.
//  2. Same frame, tx_ready toggled pseudo-randomly -> identical byte order, data
//     and tx_last stable whenever tx_valid & !tx_ready.
//  3. res_error pulse (also with res_done simultaneously) -> one byte 0xEE, tx_last=1.
//     res_done with dim=6'o77 (n=49) -> one byte 0xEE.
//  4. dim=6'o05 (rows 0) -> single header byte 0x05 with tx_last; res_done mid-frame
//     -> overrun 1-cycle pulse, frame unchanged.
//  5. With MATRIX_STREAM_CHECKSUM_EN, test 1 stimulus -> extra byte 0x1A with tx_last;
//     rst_n low after 3rd byte -> tx_valid=0 immediately, next res_done starts clean.

Source files
------------

// File: rtl/matrix_result_streamer.sv
// rtl/matrix_result_streamer.sv - captures a matrix result and streams it as a byte frame
// Optional feature: define MATRIX_STREAM_CHECKSUM_EN to append an XOR checksum byte.
module matrix_result_streamer #(
   parameter int ELEM_W    = 16,
   parameter int MAX_ELEMS = 25,
   parameter int DIM_W     = 6
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_res_done,
   input  logic                          i_res_error,
   input  logic [DIM_W-1:0]              i_res_dim,
   input  logic [MAX_ELEMS*ELEM_W-1:0]   i_res_data,
   output logic [7:0]                    o_tx_data,
   output logic                          o_tx_valid,
   input  logic                          i_tx_ready,
   output logic                          o_tx_last,
   output logic                          o_busy,
   output logic                          o_overrun
);

   localparam int                  IDX_W = $clog2(MAX_ELEMS);
   localparam int                  HALF  = DIM_W / 2;
   localparam logic [DIM_W-1:0]    MAX_N = DIM_W'(MAX_ELEMS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_E_HI = 3'd2,
      S_E_LO = 3'd3,
`ifdef MATRIX_STREAM_CHECKSUM_EN
      S_CSUM = 3'd5,
`endif
      S_ERR  = 3'd4
   } state_t;

   // State entered after the final element byte (or after the header when n is 0)
`ifdef MATRIX_STREAM_CHECKSUM_EN
   localparam state_t S_END = S_CSUM;
`else
   localparam state_t S_END = S_IDLE;
`endif

   state_t                        r_state;
   state_t                        w_state_nxt;
   logic [MAX_ELEMS*ELEM_W-1:0]   r_data;
   logic [MAX_ELEMS*ELEM_W-1:0]   w_data_nxt;
   logic [DIM_W-1:0]              r_dim;
   logic [DIM_W-1:0]              w_dim_nxt;
   logic [DIM_W-1:0]              r_n;
   logic [DIM_W-1:0]              w_n_nxt;
   logic [DIM_W-1:0]              w_n_in;
   logic [IDX_W-1:0]              r_idx;
   logic [IDX_W-1:0]              w_idx_nxt;
   logic                          w_xfer;
   logic                          w_start;
   logic                          w_last_elem;
   logic [ELEM_W-1:0]             w_elems [MAX_ELEMS];
   logic [ELEM_W-1:0]             w_elem;
   logic [7:0]                    w_tx_data_nxt;
   logic                          w_tx_last_nxt;
   logic [7:0]                    r_tx_data;
   logic                          r_tx_valid;
   logic                          r_tx_last;
   logic                          r_busy;
   logic                          r_overrun;

   assign w_n_in      = {{HALF{1'b0}}, i_res_dim[DIM_W-1:HALF]} * {{HALF{1'b0}}, i_res_dim[HALF-1:0]};
   assign w_xfer      = r_tx_valid & i_tx_ready;
   assign w_last_elem = (DIM_W'(r_idx) == r_n - DIM_W'(1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_res_error) begin
               w_state_nxt = S_ERR;
            end else if (i_res_done) begin
               if (w_n_in > MAX_N) begin
                  w_state_nxt = S_ERR;
               end else begin
                  w_state_nxt = S_HDR;
                  w_start     = 1'b1;
               end
            end
         end
         S_HDR: begin
            if (w_xfer) begin
               w_state_nxt = (r_n == '0) ? S_END : S_E_HI;
            end
         end
         S_E_HI: begin
            if (w_xfer) begin
               w_state_nxt = S_E_LO;
            end
         end
         S_E_LO: begin
            if (w_xfer) begin
               w_state_nxt = w_last_elem ? S_END : S_E_HI;
            end
         end
`ifdef MATRIX_STREAM_CHECKSUM_EN
         S_CSUM: begin
            if (w_xfer) begin
               w_state_nxt = S_IDLE;
            end
         end
`endif
         S_ERR: begin
            if (w_xfer) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Capture path: the next-cycle view lets the first header byte be registered on the done edge
   always_comb begin
      w_data_nxt = w_start ? i_res_data : r_data;
      w_dim_nxt  = w_start ? i_res_dim  : r_dim;
      w_n_nxt    = w_start ? w_n_in     : r_n;
      w_idx_nxt  = r_idx;
      if (w_start) begin
         w_idx_nxt = '0;
      end else if (r_state == S_E_LO && w_xfer) begin
         w_idx_nxt = r_idx + IDX_W'(1);
      end
   end

   always_comb begin
      for (int i = 0; i < MAX_ELEMS; i++) begin
         w_elems[i] = w_data_nxt[i*ELEM_W +: ELEM_W];
      end
   end

   assign w_elem = w_elems[w_idx_nxt];

`ifdef MATRIX_STREAM_CHECKSUM_EN
   logic [7:0] r_csum;
   logic [7:0] w_csum_nxt;

   // Running XOR of every byte already handed over in this frame
   always_comb begin
      w_csum_nxt = r_csum;
      if (w_start) begin
         w_csum_nxt = 8'h00;
      end else if (w_xfer) begin
         w_csum_nxt = r_csum ^ r_tx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_csum <= 8'h00;
      end else begin
         r_csum <= w_csum_nxt;
      end
   end
`else
   logic w_last_elem_nxt;
   assign w_last_elem_nxt = (DIM_W'(w_idx_nxt) == w_n_nxt - DIM_W'(1));
`endif

   // Output logic: byte and last flag for the state being entered
   always_comb begin
      w_tx_data_nxt = 8'h00;
      w_tx_last_nxt = 1'b0;
      case (w_state_nxt)
         S_HDR: begin
            w_tx_data_nxt = 8'(w_dim_nxt);
`ifndef MATRIX_STREAM_CHECKSUM_EN
            w_tx_last_nxt = (w_n_nxt == '0);
`endif
         end
         S_E_HI: begin
            w_tx_data_nxt = w_elem[ELEM_W-1 -: 8];
         end
         S_E_LO: begin
            w_tx_data_nxt = w_elem[7:0];
`ifndef MATRIX_STREAM_CHECKSUM_EN
            w_tx_last_nxt = w_last_elem_nxt;
`endif
         end
`ifdef MATRIX_STREAM_CHECKSUM_EN
         S_CSUM: begin
            w_tx_data_nxt = w_csum_nxt;
            w_tx_last_nxt = 1'b1;
         end
`endif
         S_ERR: begin
            w_tx_data_nxt = 8'hEE;
            w_tx_last_nxt = 1'b1;
         end
         default: begin
            w_tx_data_nxt = 8'h00;
            w_tx_last_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data     <= '0;
         r_dim      <= '0;
         r_n        <= '0;
         r_idx      <= '0;
         r_tx_data  <= 8'h00;
         r_tx_valid <= 1'b0;
         r_tx_last  <= 1'b0;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_data     <= w_data_nxt;
         r_dim      <= w_dim_nxt;
         r_n        <= w_n_nxt;
         r_idx      <= w_idx_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_tx_valid <= (w_state_nxt != S_IDLE);
         r_tx_last  <= w_tx_last_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
         r_overrun  <= (i_res_done | i_res_error) & (r_state != S_IDLE);
      end
   end

   assign o_tx_data  = r_tx_data;
   assign o_tx_valid = r_tx_valid;
   assign o_tx_last  = r_tx_last;
   assign o_busy     = r_busy;
   assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb/tb_matrix_result_streamer.sv - self-checking bench for matrix_result_streamer
// Honours MATRIX_STREAM_CHECKSUM_EN so the same bench covers both builds.
module tb_matrix_result_streamer;

`ifdef MATRIX_STREAM_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_res_done;
   logic         i_res_error;
   logic [5:0]   i_res_dim;
   logic [399:0] i_res_data;
   logic [7:0]   o_tx_data;
   logic         o_tx_valid;
   logic         i_tx_ready;
   logic         o_tx_last;
   logic         o_busy;
   logic         o_overrun;

   always #5 clk = ~clk;

   matrix_result_streamer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_res_done  (i_res_done),
      .i_res_error (i_res_error),
      .i_res_dim   (i_res_dim),
      .i_res_data  (i_res_data),
      .o_tx_data   (o_tx_data),
      .o_tx_valid  (o_tx_valid),
      .i_tx_ready  (i_tx_ready),
      .o_tx_last   (o_tx_last),
      .o_busy      (o_busy),
      .o_overrun   (o_overrun)
   );

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] got_d [$];
   bit         got_l [$];
   logic [7:0] exp_d [$];
   int         cyc = 0;
   int         first_cyc = 0;
   int         last_cyc = 0;
   int         stall_viol = 0;
   logic [7:0] prev_d = 8'h00;
   logic       prev_l = 1'b0;
   bit         prev_stall = 1'b0;

   typedef struct packed {
      bit          err;
      bit          done;
      logic [5:0]  dim;
      logic [31:0] exp_len;
      logic [7:0]  exp_first;
   } vec_t;

   vec_t tbl [9];

   // Stream monitor sampled on the falling edge, away from DUT updates
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!o_tx_valid || o_tx_data !== prev_d || o_tx_last !== prev_l))
            stall_viol++;
         if (o_tx_valid && i_tx_ready) begin
            if (got_d.size() == 0) first_cyc = cyc;
            last_cyc = cyc;
            got_d.push_back(o_tx_data);
            got_l.push_back(o_tx_last);
         end
         prev_stall = o_tx_valid && !i_tx_ready;
         prev_d     = o_tx_data;
         prev_l     = o_tx_last;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [399:0] pat_data();
      logic [399:0] d;
      for (int i = 0; i < 25; i++) d[i*16 +: 16] = {8'(2*i+1), 8'(2*i+2)};
      return d;
   endfunction

   function automatic logic [399:0] rnd_data();
      logic [399:0] d;
      for (int i = 0; i < 25; i++) d[i*16 +: 16] = 16'($urandom);
      return d;
   endfunction

   // Reference: frame contents straight from the frame rules
   task automatic build_exp(input bit err, input logic [5:0] dim, input logic [399:0] data);
      int         n;
      logic [7:0] x;
      exp_d.delete();
      n = int'(dim[5:3]) * int'(dim[2:0]);
      if (err || n > 25) begin
         exp_d.push_back(8'hEE);
      end else begin
         exp_d.push_back({2'b00, dim});
         for (int i = 0; i < n; i++) begin
            exp_d.push_back(data[i*16+8 +: 8]);
            exp_d.push_back(data[i*16 +: 8]);
         end
         if (CS == 1) begin
            x = 8'h00;
            foreach (exp_d[i]) x = x ^ exp_d[i];
            exp_d.push_back(x);
         end
      end
   endtask

   task automatic compare_frame(input string tag, input bit rnd);
      int bad_d = 0;
      int bad_l = 0;
      chk({tag, "_len"}, got_d.size(), exp_d.size());
      for (int i = 0; i < exp_d.size(); i++) begin
         if (i >= got_d.size() || got_d[i] !== exp_d[i]) bad_d++;
         if (i < got_l.size() && got_l[i] != (i == exp_d.size() - 1)) bad_l++;
      end
      chk({tag, "_data_mismatches"}, bad_d, 0);
      chk({tag, "_last_mismatches"}, bad_l, 0);
      chk({tag, "_stall_unstable"}, stall_viol, 0);
      if (!rnd) chk({tag, "_bubbles"}, last_cyc - first_cyc, exp_d.size() - 1);
   endtask

   task automatic wait_idle(input bit rnd);
      int k = 0;
      while (o_busy && k < 600) begin
         i_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         k++;
      end
   endtask

   task automatic run_frame(input bit err, input bit done, input logic [5:0] dim,
                            input logic [399:0] data, input bit rnd, input string tag);
      build_exp(err, dim, data);
      got_d.delete();
      got_l.delete();
      stall_viol = 0;
      @(posedge clk); #1;
      i_res_error = err;
      i_res_done  = done;
      i_res_dim   = dim;
      i_res_data  = data;
      i_tx_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      i_res_error = 1'b0;
      i_res_done  = 1'b0;
      i_res_dim   = 6'($urandom);
      i_res_data  = rnd_data();
      chk({tag, "_valid_latency"}, o_tx_valid, 1);
      wait_idle(rnd);
      chk({tag, "_busy_end"}, o_busy, 0);
      chk({tag, "_last_clear"}, o_tx_last, 0);
      compare_frame(tag, rnd);
   endtask

   initial begin
      logic [7:0] t1 [10];
      int         k;
      int         bad;
      bit         e;

      tbl[0] = '{1'b0, 1'b1, 6'o22, 32'(9 + CS),  8'h12};
      tbl[1] = '{1'b1, 1'b0, 6'o22, 32'd1,        8'hEE};
      tbl[2] = '{1'b1, 1'b1, 6'o22, 32'd1,        8'hEE};
      tbl[3] = '{1'b0, 1'b1, 6'o77, 32'd1,        8'hEE};
      tbl[4] = '{1'b0, 1'b1, 6'o05, 32'(1 + CS),  8'h05};
      tbl[5] = '{1'b0, 1'b1, 6'o55, 32'(51 + CS), 8'h2D};
      tbl[6] = '{1'b0, 1'b1, 6'o66, 32'd1,        8'hEE};
      tbl[7] = '{1'b0, 1'b1, 6'o13, 32'(7 + CS),  8'h0B};
      tbl[8] = '{1'b0, 1'b1, 6'o50, 32'(1 + CS),  8'h28};

      t1 = '{8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1A};

      rst_n       = 1'b0;
      i_res_done  = 1'b0;
      i_res_error = 1'b0;
      i_res_dim   = 6'o00;
      i_res_data  = '0;
      i_tx_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_data", o_tx_data, 0);
      chk("rst_tx_valid", o_tx_valid, 0);
      chk("rst_tx_last", o_tx_last, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_overrun", o_overrun, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 9; v++) begin
         run_frame(tbl[v].err, tbl[v].done, tbl[v].dim, pat_data(), 1'b0, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d_tbl_len", v), got_d.size(), tbl[v].exp_len);
         chk($sformatf("vec%0d_tbl_first", v), got_d.size() > 0 ? 32'(got_d[0]) : 32'hFFFF, 32'(tbl[v].exp_first));
      end

      // Fixed 2x2 frame against literal bytes
      run_frame(1'b0, 1'b1, 6'o22, pat_data(), 1'b0, "t1");
      bad = 0;
      for (int i = 0; i < 9 + CS; i++) if (got_d[i] !== t1[i]) bad++;
      chk("t1_literal_bytes", bad, 0);
      chk("t1_last_pos", got_l.size() > 0 ? 32'(got_l[got_l.size()-1]) : 0, 1);

      for (int r = 0; r < 3; r++)
         run_frame(1'b0, 1'b1, 6'o22, pat_data(), 1'b1, $sformatf("t2_rnd%0d", r));

      for (int r = 0; r < 25; r++) begin
         e = ($urandom_range(0, 5) == 0);
         run_frame(e, 1'b1, 6'($urandom), rnd_data(), 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
      end

      // res_done while busy: one-cycle overrun, frame unaffected
      build_exp(1'b0, 6'o22, pat_data());
      got_d.delete();
      got_l.delete();
      stall_viol = 0;
      i_tx_ready = 1'b1;
      @(posedge clk); #1;
      i_res_done = 1'b1; i_res_dim = 6'o22; i_res_data = pat_data();
      @(posedge clk); #1;
      i_res_done = 1'b0;
      chk("ovr_idle_no_pulse", o_overrun, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      i_res_done = 1'b1; i_res_dim = 6'o33; i_res_data = rnd_data();
      @(posedge clk); #1;
      i_res_done = 1'b0;
      chk("ovr_pulse", o_overrun, 1);
      @(posedge clk); #1;
      chk("ovr_pulse_end", o_overrun, 0);
      wait_idle(1'b0);
      chk("ovr_busy_end", o_busy, 0);
      compare_frame("ovr", 1'b0);

      // Reset mid-frame after the third byte
      got_d.delete();
      got_l.delete();
      @(posedge clk); #1;
      i_res_done = 1'b1; i_res_dim = 6'o22; i_res_data = pat_data();
      @(posedge clk); #1;
      i_res_done = 1'b0;
      k = 0;
      while (got_d.size() < 3 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("mrst_third_byte", got_d.size(), 3);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_valid_async", o_tx_valid, 0);
      chk("mrst_busy_async", o_busy, 0);
      chk("mrst_last_async", o_tx_last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(1'b0, 1'b1, 6'o22, pat_data(), 1'b0, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
